// File: rtl/stream_pkg.sv
// stream_pkg: shared helpers for the stream width-conversion blocks
//   onehot_single : true when exactly one bit of a mask (up to 64 bits) is set
//   lane_w        : width of a lane index for n lanes
package stream_pkg;
   function automatic logic onehot_single(input logic [63:0] v);
      return (v != '0) && ((v & (v - 64'd1)) == '0);
   endfunction
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/stream_downsizer_keep_if.sv
// stream_downsizer_keep_if: wide-in / narrow-out stream bundle with keep mask
//   slave  : the downsizer side (takes s_*, m_ready_i; drives s_ready_o, m_*, err_drop_o)
//   master : the environment side (mirror of slave)
interface stream_downsizer_keep_if import stream_pkg::*; #(
   parameter int DW_OUT = 8,
   parameter int SCALE = 4
);
   localparam int LW = lane_w(SCALE);
   logic [DW_OUT*SCALE-1:0] s_data_i;
   logic [SCALE-1:0] s_keep_i;
   logic s_last_i;
   logic s_valid_i;
   logic s_ready_o;
   logic [DW_OUT-1:0] m_data_o;
   logic [LW-1:0] m_lane_o;
   logic m_last_o;
   logic m_valid_o;
   logic m_ready_i;
   logic err_drop_o;
   modport slave (
      input s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
      output s_ready_o, m_data_o, m_lane_o, m_last_o, m_valid_o, err_drop_o
   );
   modport master (
      output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
      input s_ready_o, m_data_o, m_lane_o, m_last_o, m_valid_o, err_drop_o
   );
endinterface

// File: rtl/lane_pick.sv
// lane_pick: priority encoder picking the lowest (or highest when MSB_FIRST) set lane
//   mask_i : lane mask in
//   hot_o  : one-hot of the picked lane (zero when mask_i is zero)
//   idx_o  : index of the picked lane (zero when mask_i is zero)
module lane_pick import stream_pkg::*; #(
   parameter int SCALE = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic [SCALE-1:0] mask_i,
   output logic [SCALE-1:0] hot_o,
   output logic [lane_w(SCALE)-1:0] idx_o
);
   localparam int LW = lane_w(SCALE);
   // later iterations override earlier ones, so the scan direction sets the priority
   always_comb begin
      idx_o = '0;
      for (int i = 0; i < SCALE; i++) begin
         if (MSB_FIRST) begin
            if (mask_i[i]) idx_o = LW'(i);
         end else if (mask_i[SCALE-1-i]) idx_o = LW'(SCALE-1-i);
      end
      hot_o = '0;
      hot_o[idx_o] = |mask_i;
   end
endmodule

// File: rtl/stream_downsizer_keep.sv
// stream_downsizer_keep: splits a SCALE-lane wide beat into kept narrow lanes, zero-bubble
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream_downsizer_keep_if.slave (wide s_* in, narrow m_* out, err_drop_o pulse)
//   STREAM_DOWNSIZER_MSB_FIRST_EN : when defined, lanes are emitted highest-first
module stream_downsizer_keep import stream_pkg::*; #(
   parameter int DW_OUT = 8,
   parameter int SCALE = 4
) (
   input logic clk,
   input logic rst,
   stream_downsizer_keep_if.slave bus
);
   localparam int LW = lane_w(SCALE);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif
   logic [DW_OUT*SCALE-1:0] data_r;
   logic [SCALE-1:0] rem_r, hot;
   logic [LW-1:0] sel;
   logic last_r, full, rst_r, err_r, wr, rd, one, fin, kept;
   lane_pick #(.SCALE(SCALE), .MSB_FIRST(MSB_FIRST)) u_pick (
      .mask_i(rem_r),
      .hot_o(hot),
      .idx_o(sel)
   );
   assign one = onehot_single(64'(rem_r));
   assign rd = full & bus.m_ready_i;
   assign fin = rd & one;
   assign bus.s_ready_o = (!full | fin) & !rst_r & !rst;
   assign wr = bus.s_valid_i & bus.s_ready_o;
   assign kept = |bus.s_keep_i;
   assign bus.m_valid_o = full;
   assign bus.m_data_o = data_r[sel*DW_OUT +: DW_OUT];
   assign bus.m_lane_o = sel;
   assign bus.m_last_o = last_r & one;
   assign bus.err_drop_o = err_r;
   always_ff @(posedge clk) if (wr && kept) data_r <= bus.s_data_i;
   // an all-zero-keep beat is consumed without touching the held state
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         rem_r <= '0;
         last_r <= 1'b0;
         err_r <= 1'b0;
         rst_r <= 1'b1;
      end else begin
         rst_r <= 1'b0;
         err_r <= wr & !kept & bus.s_last_i;
         if (wr && kept) begin
            rem_r <= bus.s_keep_i;
            last_r <= bus.s_last_i;
            full <= 1'b1;
         end else if (fin) begin
            rem_r <= '0;
            full <= 1'b0;
         end else if (rd) rem_r <= rem_r & ~hot;
      end
   end
endmodule

// File: tb/tb_stream_downsizer_keep.sv
// tb_stream_downsizer_keep: directed self-checking bench for stream_downsizer_keep (DW_OUT=8, SCALE=4)
module tb_stream_downsizer_keep;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   stream_downsizer_keep_if #(.DW_OUT(8), .SCALE(4)) sif ();
   stream_downsizer_keep #(.DW_OUT(8), .SCALE(4)) dut (.clk(clk), .rst(rst), .bus(sif));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      sif.s_data_i = d;
      sif.s_keep_i = k;
      sif.s_last_i = l;
      sif.s_valid_i = 1'b1;
   endtask
   task automatic expect_lane(input string tag, input logic [7:0] d, input logic [1:0] ln, input logic l);
      #1;
      check({tag, "_valid"}, 32'(sif.m_valid_o), 32'd1);
      check({tag, "_data"}, 32'(sif.m_data_o), 32'(d));
      check({tag, "_lane"}, 32'(sif.m_lane_o), 32'(ln));
      check({tag, "_last"}, 32'(sif.m_last_o), 32'(l));
      tick();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] d;
      int idx;
      int cyc;
      sif.s_data_i = '0;
      sif.s_keep_i = '0;
      sif.s_last_i = 1'b0;
      sif.s_valid_i = 1'b0;
      sif.m_ready_i = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(sif.m_valid_o), 32'd0);
      check("rst_ready", 32'(sif.s_ready_o), 32'd0);
      check("rst_err", 32'(sif.err_drop_o), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_ready_blocked", 32'(sif.s_ready_o), 32'd0);
      tick();
      check("post_rst_ready", 32'(sif.s_ready_o), 32'd1);
      check("post_rst_last", 32'(sif.m_last_o), 32'd0);
      // full beat
      beat(32'h44332211, 4'b1111, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      expect_lane("full0", 8'h11, 2'd0, 1'b0);
      expect_lane("full1", 8'h22, 2'd1, 1'b0);
      #1;
      check("full_ready_mid", 32'(sif.s_ready_o), 32'd0);
      expect_lane("full2", 8'h33, 2'd2, 1'b0);
      #1;
      check("full_ready_fin", 32'(sif.s_ready_o), 32'd1);
      expect_lane("full3", 8'h44, 2'd3, 1'b1);
      check("full_idle", 32'(sif.m_valid_o), 32'd0);
      // sparse beat
      beat(32'hDDCCBBAA, 4'b1010, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      expect_lane("sparse0", 8'hBB, 2'd1, 1'b0);
      expect_lane("sparse1", 8'hDD, 2'd3, 1'b1);
      check("sparse_idle", 32'(sif.m_valid_o), 32'd0);
      // back-to-back: beat b lane l carries byte 16*b+l
      beat(32'h03020100, 4'b1111, 1'b0);
      tick();
      beat(32'h13121110, 4'b1111, 1'b0);
      for (int k = 0; k < 12; k++) begin
         #1;
         check("b2b_ready", 32'(sif.s_ready_o), 32'(k % 4 == 3));
         expect_lane("b2b", 8'(16 * (k / 4) + k % 4), 2'(k % 4), k == 11);
         if (k == 3) beat(32'h23222120, 4'b1111, 1'b1);
         if (k == 7) sif.s_valid_i = 1'b0;
      end
      check("b2b_idle", 32'(sif.m_valid_o), 32'd0);
      // random output stalls: held lane must stay put until taken
      beat(32'h88776655, 4'b1111, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      d = 32'h88776655;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 100) begin
         sif.m_ready_i = 1'($urandom_range(0, 1));
         #1;
         check("stall_valid", 32'(sif.m_valid_o), 32'd1);
         check("stall_data", 32'(sif.m_data_o), 32'(d[idx*8 +: 8]));
         check("stall_lane", 32'(sif.m_lane_o), 32'(idx));
         check("stall_last", 32'(sif.m_last_o), 32'(idx == 3));
         if (sif.m_ready_i) idx++;
         cyc++;
         tick();
      end
      check("stall_done", 32'(idx), 32'd4);
      sif.m_ready_i = 1'b1;
      #1;
      check("stall_idle", 32'(sif.m_valid_o), 32'd0);
      // zero keep, with and without last
      beat(32'h12345678, 4'b0000, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      check("drop_err", 32'(sif.err_drop_o), 32'd1);
      check("drop_valid", 32'(sif.m_valid_o), 32'd0);
      tick();
      check("drop_err_pulse", 32'(sif.err_drop_o), 32'd0);
      beat(32'h12345678, 4'b0000, 1'b0);
      tick();
      sif.s_valid_i = 1'b0;
      check("quiet_err", 32'(sif.err_drop_o), 32'd0);
      check("quiet_valid", 32'(sif.m_valid_o), 32'd0);
      // reset mid-beat
      beat(32'h04030201, 4'b1111, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      expect_lane("mid0", 8'h01, 2'd0, 1'b0);
      expect_lane("mid1", 8'h02, 2'd1, 1'b0);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 32'(sif.m_valid_o), 32'd0);
      check("mid_rst_ready", 32'(sif.s_ready_o), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_ready_blocked", 32'(sif.s_ready_o), 32'd0);
      tick();
      check("mid_ready_back", 32'(sif.s_ready_o), 32'd1);
      beat(32'hA0B0C0D0, 4'b0011, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
      expect_lane("after0", 8'hD0, 2'd0, 1'b0);
      expect_lane("after1", 8'hC0, 2'd1, 1'b1);
      // keep 0111: order depends on the build
      beat(32'h00332211, 4'b0111, 1'b1);
      tick();
      sif.s_valid_i = 1'b0;
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
      expect_lane("ord0", 8'h33, 2'd2, 1'b0);
      expect_lane("ord1", 8'h22, 2'd1, 1'b0);
      expect_lane("ord2", 8'h11, 2'd0, 1'b1);
`else
      expect_lane("ord0", 8'h11, 2'd0, 1'b0);
      expect_lane("ord1", 8'h22, 2'd1, 1'b0);
      expect_lane("ord2", 8'h33, 2'd2, 1'b1);
`endif
      check("ord_idle", 32'(sif.m_valid_o), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
